// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the program loader and the fetch/decode side.
//   Field widths of the 8-bit instruction word, the two address-format
//   opcodes, and the loader FSM state type.
package cpu_pkg;

    localparam int OPCODE_W = 3;
    localparam int IMM_W    = 3;
    localparam int ADDR_W   = 5;
    localparam int WORD_W   = 8;

    localparam logic [OPCODE_W-1:0] OP_J   = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    // Jumps and branches carry a 5-bit target instead of rd/rs/imm.
    function automatic logic is_addr_format(input logic [OPCODE_W-1:0] opcode);
        return (opcode == OP_J) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/program_loader_instr_encoder.sv
// instr_encoder -- packs instruction fields into an 8-bit program word.
//   This is the exact inverse of the fetch decode.
//   Ports:
//     opcode[2:0], rd, rs, imm[2:0], address[4:0]  in   instruction fields
//     word[7:0]                                    out  encoded word
//   Register format: {opcode, rd, rs, imm}
//   Address format (OP_J, OP_BEQ): {opcode, address}
module instr_encoder
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                rd,
    input  logic                rs,
    input  logic [IMM_W-1:0]    imm,
    input  logic [ADDR_W-1:0]   address,
    output logic [WORD_W-1:0]   word
);

    // NOTE: every output of an always_comb block gets a default value first,
    // so that no path leaves it unassigned and no latch can be inferred.
    always_comb begin
        word = {opcode, rd, rs, imm};
        if (is_addr_format(opcode)) begin
            word = {opcode, address};
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader -- streams encoded instructions into program RAM.
//   A session starts with `start` (pointer <- base_addr) and ends on `finish`
//   or after word 255 is written. Each accepted field set is encoded and
//   written one cycle later.
//   Ports:
//     clk, rst (sync, active high)
//     start, base_addr[7:0], finish                  session control
//     in_valid / in_ready, in_opcode, in_rd, in_rs,
//       in_imm, in_address                           instruction field input
//     mem_we, mem_waddr[7:0], mem_wdata[7:0]         program-RAM write port
//     busy, done, overflow, word_count[8:0]          status
//     checksum[7:0]                                  only with PROG_LOADER_CHECKSUM_EN
//   Optional feature: define PROG_LOADER_CHECKSUM_EN to add `checksum`, the
//   XOR of all words written in the current session.
module program_loader
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          base_addr,
    input  logic                finish,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic                in_rd,
    input  logic                in_rs,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic [ADDR_W-1:0]   in_address,
    output logic                mem_we,
    output logic [7:0]          mem_waddr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [8:0]          word_count
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0]   checksum
`endif
);

    loader_state_t     state, next_state;
    logic [7:0]        ptr;
    logic [WORD_W-1:0] enc_word;
    logic              xfer;
    logic              last_word;

    instr_encoder u_encoder (
        .opcode  (in_opcode),
        .rd      (in_rd),
        .rs      (in_rs),
        .imm     (in_imm),
        .address (in_address),
        .word    (enc_word)
    );

    // in_ready is only ever high in LOAD, so it alone qualifies a transfer.
    assign xfer      = in_valid && in_ready;
    assign last_word = xfer && (ptr == 8'hFF);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (finish || last_word) next_state = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_waddr  <= 8'h00;
            mem_wdata  <= '0;
            ptr        <= 8'h00;
            word_count <= 9'd0;
            overflow   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            // Registered ready: high exactly while the FSM sits in LOAD.
            in_ready <= (next_state == LOAD);
            mem_we   <= xfer;

            if ((state == IDLE) && start) begin
                ptr        <= base_addr;
                word_count <= 9'd0;
                overflow   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                checksum   <= '0;
`endif
            end

            if (xfer) begin
                mem_waddr  <= ptr;
                mem_wdata  <= enc_word;
                word_count <= word_count + 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                checksum   <= checksum ^ enc_word;
`endif
                // The pointer saturates at 255; overflow records that the
                // session hit the end of program RAM.
                if (ptr == 8'hFF) begin
                    overflow <= 1'b1;
                end else begin
                    ptr <= ptr + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader -- directed self-checking bench for program_loader.
//   Inputs change #1 after a rising edge; outputs are sampled at that point.
//   Define PROG_LOADER_CHECKSUM_EN to also exercise the checksum output.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic       finish;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic       in_rd;
    logic       in_rs;
    logic [2:0] in_imm;
    logic [4:0] in_address;
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [8:0] word_count;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .finish     (finish),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_imm     (in_imm),
        .in_address (in_address),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
`ifdef PROG_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] op, input logic rd, input logic rs,
                              input logic [2:0] imm, input logic [4:0] addr);
        in_opcode  = op;
        in_rd      = rd;
        in_rs      = rs;
        in_imm     = imm;
        in_address = addr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"},   32'(in_ready),   32'd0);
        check({tag, ".mem_we"},     32'(mem_we),     32'd0);
        check({tag, ".mem_waddr"},  32'(mem_waddr),  32'h00);
        check({tag, ".mem_wdata"},  32'(mem_wdata),  32'h00);
        check({tag, ".busy"},       32'(busy),       32'd0);
        check({tag, ".done"},       32'(done),       32'd0);
        check({tag, ".overflow"},   32'(overflow),   32'd0);
        check({tag, ".word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 8'h00; finish = 1'b0; in_valid = 1'b0;
        set_fields(3'b000, 1'b0, 1'b0, 3'b000, 5'b00000);
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // finish outside LOAD does nothing
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("idle_finish.done", 32'(done), 32'd0);
        check("idle_finish.busy", 32'(busy), 32'd0);

        // Register format at 0x10: {010,1,0,101} = 0x55
        start = 1'b1; base_addr = 8'h10;
        tick();
        start = 1'b0;
        check("reg.in_ready", 32'(in_ready), 32'd1);
        check("reg.busy",     32'(busy),     32'd1);
        in_valid = 1'b1; set_fields(3'b010, 1'b1, 1'b0, 3'b101, 5'b11111);
        tick();
        in_valid = 1'b0;
        check("reg.mem_we",    32'(mem_we),     32'd1);
        check("reg.mem_waddr", 32'(mem_waddr),  32'h10);
        check("reg.mem_wdata", 32'(mem_wdata),  32'h55);
        check("reg.word_count",32'(word_count), 32'd1);
        tick();
        check("reg.we_pulse",  32'(mem_we),     32'd0);
        check("reg.hold_addr", 32'(mem_waddr),  32'h10);
        check("reg.hold_data", 32'(mem_wdata),  32'h55);

        // Address format: {110,10011} = 0xD3, rd/rs/imm ignored
        in_valid = 1'b1; set_fields(3'b110, 1'b1, 1'b1, 3'b111, 5'b10011);
        tick();
        in_valid = 1'b0;
        check("addr.mem_we",    32'(mem_we),    32'd1);
        check("addr.mem_waddr", 32'(mem_waddr), 32'h11);
        check("addr.mem_wdata", 32'(mem_wdata), 32'hD3);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("addr.done",       32'(done),       32'd1);
        check("addr.in_ready",   32'(in_ready),   32'd0);
        check("addr.word_count", 32'(word_count), 32'd2);
        tick();
        check("addr.done_end",   32'(done),       32'd0);
        check("addr.idle_busy",  32'(busy),       32'd0);
        check("addr.wc_hold",    32'(word_count), 32'd2);

        // Burst with gaps at 0x40; words {001,0,0,i} = 0x20+i.
        // A stray start mid-session must not move the pointer.
        start = 1'b1; base_addr = 8'h40;
        tick();
        start = 1'b0;
        check("burst.wc_clear", 32'(word_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; set_fields(3'b001, 1'b0, 1'b0, 3'(i), 5'b00000);
            if (i == 2) begin
                start = 1'b1; base_addr = 8'h00;
            end
            tick();
            in_valid = 1'b0; start = 1'b0;
            check($sformatf("burst%0d.mem_we", i),    32'(mem_we),    32'd1);
            check($sformatf("burst%0d.mem_waddr", i), 32'(mem_waddr), 32'h40 + 32'(i));
            check($sformatf("burst%0d.mem_wdata", i), 32'(mem_wdata), 32'h20 + 32'(i));
            tick();
            check($sformatf("burst%0d.gap_we", i),    32'(mem_we),    32'd0);
        end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("burst.done",       32'(done),       32'd1);
        check("burst.word_count", 32'(word_count), 32'd5);
        tick();
        check("burst.done_once",  32'(done),       32'd0);

        // Pointer limit at 0xFE with three words offered back to back
        start = 1'b1; base_addr = 8'hFE;
        tick();
        start = 1'b0;
        in_valid = 1'b1; set_fields(3'b011, 1'b0, 1'b0, 3'b001, 5'b00000);
        tick();
        check("limit.w0_we",    32'(mem_we),    32'd1);
        check("limit.w0_addr",  32'(mem_waddr), 32'hFE);
        check("limit.w0_ovf",   32'(overflow),  32'd0);
        tick();
        check("limit.w1_we",    32'(mem_we),     32'd1);
        check("limit.w1_addr",  32'(mem_waddr),  32'hFF);
        check("limit.ovf",      32'(overflow),   32'd1);
        check("limit.in_ready", 32'(in_ready),   32'd0);
        check("limit.done",     32'(done),       32'd1);
        tick();
        check("limit.w2_we",    32'(mem_we),     32'd0);
        check("limit.w2_addr",  32'(mem_waddr),  32'hFF);
        check("limit.wc",       32'(word_count), 32'd2);
        tick();
        in_valid = 1'b0;
        check("limit.idle_we",  32'(mem_we),     32'd0);
        check("limit.ovf_hold", 32'(overflow),   32'd1);

        // Simultaneous finish and transfer: {011,0,1,010} = 0x6A
        start = 1'b1; base_addr = 8'h80;
        tick();
        start = 1'b0;
        check("simul.ovf_clear", 32'(overflow), 32'd0);
        in_valid = 1'b1; finish = 1'b1; set_fields(3'b011, 1'b0, 1'b1, 3'b010, 5'b00000);
        tick();
        in_valid = 1'b0; finish = 1'b0;
        check("simul.mem_we",    32'(mem_we),    32'd1);
        check("simul.mem_waddr", 32'(mem_waddr), 32'h80);
        check("simul.mem_wdata", 32'(mem_wdata), 32'h6A);
        check("simul.done",      32'(done),      32'd1);
        check("simul.in_ready",  32'(in_ready),  32'd0);
        tick();
        check("simul.we_end",    32'(mem_we),    32'd0);
        check("simul.done_end",  32'(done),      32'd0);

        // Reset mid-session, in the same cycle as a transfer
        start = 1'b1; base_addr = 8'h20;
        tick();
        start = 1'b0;
        in_valid = 1'b1; set_fields(3'b100, 1'b1, 1'b1, 3'b011, 5'b00000);
        tick();
        check("rstmid.first_we", 32'(mem_we), 32'd1);
        rst = 1'b1; start = 1'b1; finish = 1'b1;
        tick();
        check_reset_outputs("rstmid");
        rst = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        tick();
        check("rstmid.after_we", 32'(mem_we), 32'd0);
        check("rstmid.after_busy", 32'(busy), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // 0xA5 = {101,0,0,101}, 0x0F = {000,0,1,111}; XOR = 0xAA
        start = 1'b1; base_addr = 8'h00;
        tick();
        start = 1'b0;
        check("csum.clear", 32'(checksum), 32'h00);
        in_valid = 1'b1; set_fields(3'b101, 1'b0, 1'b0, 3'b101, 5'b00000);
        tick();
        check("csum.w0_data", 32'(mem_wdata), 32'hA5);
        check("csum.w0",      32'(checksum),  32'hA5);
        set_fields(3'b000, 1'b0, 1'b1, 3'b111, 5'b00000);
        tick();
        in_valid = 1'b0;
        check("csum.w1_data", 32'(mem_wdata), 32'h0F);
        check("csum.final",   32'(checksum),  32'hAA);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
        check("csum.hold",    32'(checksum),  32'hAA);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
